// File: rtl/tsp_solver.sv
// tsp_solver: free-running travelling-salesman heuristic.
// After reset the block spends N cycles placing N cities from an xorshift32
// stream. It then alternates PICK/EVAL forever. Each PICK draws a random segment
// [a,b]. Each EVAL applies the 2-opt reversal of that segment when the reversal
// shortens the closed Manhattan tour.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   xs    out  [W-1:0] xs[N-1:0]   x coordinate of city k (zero-extended)
//   ys    out  [W-1:0] ys[N-1:0]   y coordinate of city k (zero-extended)
//   path  out  [W-1:0] path[N-1:0] city visited at tour position p
module tsp_solver #(
  parameter int          N     = 64,
  parameter int          W     = 32,
  parameter int          CBITS = 10,
  parameter logic [31:0] SEED  = 32'h2463534A
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] xs   [N-1:0],
  output logic [W-1:0] ys   [N-1:0],
  output logic [W-1:0] path [N-1:0]
);
  localparam int IW = $clog2(N);
  localparam int DW = CBITS + 4;

  typedef enum logic [1:0] {S_INIT, S_PICK, S_EVAL} state_t;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_rng, w_rng_nxt;
  logic [IW-1:0]     r_k, r_a, r_b;
  logic [CBITS-1:0]  r_xs   [N-1:0];
  logic [CBITS-1:0]  r_ys   [N-1:0];
  logic [IW-1:0]     r_path [N-1:0];
  logic [IW-1:0]     w_path_nxt [N-1:0];

  logic [IW-1:0]     w_i, w_j, w_am1, w_bp1;
  logic [IW-1:0]     w_cp, w_ca, w_cb, w_cq;
  logic [CBITS:0]    w_d_pb, w_d_aq, w_d_pa, w_d_bq;
  logic [DW-1:0]     w_delta;
  logic              w_do_swap;

  function automatic logic [31:0] xorshift32(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  function automatic logic [CBITS:0] mdist(input logic [CBITS-1:0] x0, input logic [CBITS-1:0] y0,
                                           input logic [CBITS-1:0] x1, input logic [CBITS-1:0] y1);
    logic [CBITS-1:0] dx, dy;
    dx = (x0 > x1) ? (x0 - x1) : (x1 - x0);
    dy = (y0 > y1) ? (y0 - y1) : (y1 - y0);
    return {1'b0, dx} + {1'b0, dy};
  endfunction

  assign w_rng_nxt = xorshift32(r_rng);
  assign w_i       = w_rng_nxt[IW-1:0];
  assign w_j       = w_rng_nxt[8 +: IW];

  // Neighbour positions wrap naturally in IW-bit arithmetic (N is a power of two).
  assign w_am1 = r_a - IW'(1);
  assign w_bp1 = r_b + IW'(1);
  assign w_cp  = r_path[w_am1];
  assign w_ca  = r_path[r_a];
  assign w_cb  = r_path[r_b];
  assign w_cq  = r_path[w_bp1];

  assign w_d_pb = mdist(r_xs[w_cp], r_ys[w_cp], r_xs[w_cb], r_ys[w_cb]);
  assign w_d_aq = mdist(r_xs[w_ca], r_ys[w_ca], r_xs[w_cq], r_ys[w_cq]);
  assign w_d_pa = mdist(r_xs[w_cp], r_ys[w_cp], r_xs[w_ca], r_ys[w_ca]);
  assign w_d_bq = mdist(r_xs[w_cb], r_ys[w_cb], r_xs[w_cq], r_ys[w_cq]);

  // Two's-complement difference; |delta| <= 2*2^(CBITS+1), so DW bits cannot overflow.
  assign w_delta = DW'(w_d_pb) + DW'(w_d_aq) - DW'(w_d_pa) - DW'(w_d_bq);

  // (0,N-1) reverses the whole ring: same tour, so it is excluded as a no-op.
  assign w_do_swap = (r_state == S_EVAL) && (r_a != r_b) &&
                     !((r_a == '0) && (r_b == IW'(N-1))) && w_delta[DW-1];

  // Mirror index a+b-p stays inside [a,b], so no wrap handling is needed here.
  always_comb begin
    for (int p = 0; p < N; p++) begin
      w_path_nxt[p] = r_path[p];
      if (w_do_swap && (IW'(p) >= r_a) && (IW'(p) <= r_b))
        w_path_nxt[p] = r_path[r_a + r_b - IW'(p)];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (r_k == IW'(N-1)) w_state_nxt = S_PICK;
      S_PICK:  w_state_nxt = S_EVAL;
      S_EVAL:  w_state_nxt = S_PICK;
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rng <= SEED;
      r_k   <= '0;
      r_a   <= '0;
      r_b   <= '0;
      for (int k = 0; k < N; k++) begin
        r_xs[k]   <= '0;
        r_ys[k]   <= '0;
        r_path[k] <= IW'(k);
      end
    end else begin
      case (r_state)
        S_INIT: begin
          r_rng     <= w_rng_nxt;
          r_xs[r_k] <= w_rng_nxt[CBITS-1:0];
          r_ys[r_k] <= w_rng_nxt[16 +: CBITS];
          r_k       <= r_k + IW'(1);
        end
        S_PICK: begin
          r_rng <= w_rng_nxt;
          r_a   <= (w_i < w_j) ? w_i : w_j;
          r_b   <= (w_i < w_j) ? w_j : w_i;
        end
        S_EVAL: r_path <= w_path_nxt;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_out
    assign xs[g]   = W'(r_xs[g]);
    assign ys[g]   = W'(r_ys[g]);
    assign path[g] = W'(r_path[g]);
  end

endmodule

// File: tb/tb_tsp_solver.sv
// Bench for tsp_solver: directed reset/placement vectors from a table, plus a
// cycle-by-cycle software 2-opt model, invariant sampling and a mid-run reset.
module tb_tsp_solver;
  localparam int          N     = 64;
  localparam int          W     = 32;
  localparam int          CBITS = 10;
  localparam int          IW    = 6;
  localparam logic [31:0] SEED  = 32'h2463534A;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] xs   [N-1:0];
  logic [W-1:0] ys   [N-1:0];
  logic [W-1:0] path [N-1:0];

  tsp_solver #(.N(N), .W(W), .CBITS(CBITS), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .xs(xs), .ys(ys), .path(path)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- directed vectors ----------------
  // kind: 0 = path[idx], 1 = xs[idx], 2 = ys[idx]
  // phase 0: while held in reset (also reused for the asynchronous mid-run reset)
  // phase 1: N+1 cycles after release (placement done, first EVAL not yet applied)
  typedef struct {
    string name;
    int    phase;
    int    kind;
    int    idx;
    int    exp;
  } vec_t;
  vec_t vt[$];

  task automatic apply_vec(input int ph, input string tag);
    foreach (vt[i]) begin
      if (vt[i].phase == ph) begin
        longint act;
        case (vt[i].kind)
          0:       act = path[vt[i].idx];
          1:       act = xs[vt[i].idx];
          default: act = ys[vt[i].idx];
        endcase
        check($sformatf("%s %s", tag, vt[i].name), act, vt[i].exp);
      end
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_rng;
  int m_state, m_k, m_a, m_b;
  int m_xs [N];
  int m_ys [N];
  int m_path [N];
  int cov_eq = 0, cov_full = 0, cov_a0 = 0, cov_b63 = 0, cov_swap = 0;

  function automatic logic [31:0] ref_xorshift(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    r = r ^ (r << 13);
    r = r ^ (r >> 17);
    r = r ^ (r << 5);
    return r;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int mod_d(input int u, input int v);
    return iabs(m_xs[u] - m_xs[v]) + iabs(m_ys[u] - m_ys[v]);
  endfunction

  task automatic model_reset();
    m_rng = SEED; m_state = 0; m_k = 0; m_a = 0; m_b = 0;
    for (int k = 0; k < N; k++) begin
      m_xs[k] = 0; m_ys[k] = 0; m_path[k] = k;
    end
  endtask

  task automatic model_step();
    int i, j, cp, ca, cb, cq, delta;
    int tmp [N];
    case (m_state)
      0: begin
        m_rng = ref_xorshift(m_rng);
        m_xs[m_k] = int'(m_rng[9:0]);
        m_ys[m_k] = int'(m_rng[25:16]);
        m_k++;
        if (m_k == N) m_state = 1;
      end
      1: begin
        m_rng = ref_xorshift(m_rng);
        i = int'(m_rng[5:0]);
        j = int'(m_rng[13:8]);
        m_a = (i < j) ? i : j;
        m_b = (i < j) ? j : i;
        m_state = 2;
      end
      default: begin
        cp = m_path[(m_a + N - 1) % N];
        ca = m_path[m_a];
        cb = m_path[m_b];
        cq = m_path[(m_b + 1) % N];
        delta = mod_d(cp, cb) + mod_d(ca, cq) - mod_d(cp, ca) - mod_d(cb, cq);
        if (m_a == m_b) cov_eq++;
        if (m_a == 0 && m_b == N-1) cov_full++;
        if (m_a == 0) cov_a0++;
        if (m_b == N-1) cov_b63++;
        if (m_a != m_b && !(m_a == 0 && m_b == N-1) && delta < 0) begin
          cov_swap++;
          tmp = m_path;
          for (int p = m_a; p <= m_b; p++) m_path[p] = tmp[m_a + m_b - p];
        end
        m_state = 1;
      end
    endcase
  endtask

  // ---------------- DUT observers ----------------
  function automatic int mismatches();
    int e = 0;
    for (int k = 0; k < N; k++) begin
      if (xs[k]   !== 32'(m_xs[k]))   e++;
      if (ys[k]   !== 32'(m_ys[k]))   e++;
      if (path[k] !== 32'(m_path[k])) e++;
    end
    return e;
  endfunction

  function automatic bit is_perm();
    logic [N-1:0] seen = '0;
    for (int p = 0; p < N; p++) begin
      if (path[p] >= N) return 1'b0;
      if (seen[path[p][IW-1:0]]) return 1'b0;
      seen[path[p][IW-1:0]] = 1'b1;
    end
    return 1'b1;
  endfunction

  function automatic int cdist(input int u, input int v);
    return iabs(int'(xs[u]) - int'(xs[v])) + iabs(int'(ys[u]) - int'(ys[v]));
  endfunction

  function automatic int dut_len();
    int s = 0;
    for (int p = 0; p < N; p++)
      s += cdist(int'(path[p][IW-1:0]), int'(path[(p+1)%N][IW-1:0]));
    return s;
  endfunction

  function automatic int ident_len();
    int s = 0;
    for (int p = 0; p < N; p++) s += cdist(p, (p+1)%N);
    return s;
  endfunction

  // Runs ncyc cycles from a freshly released reset, comparing against the model.
  task automatic run(input int ncyc, input string tag);
    int bad = 0, perm_bad = 0, incr_bad = 0, range_bad = 0, frozen_bad = 0;
    int prev_len = -1, len;
    logic [W-1:0] snap_x [N];
    logic [W-1:0] snap_y [N];
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      bad += mismatches();
      if (c == N + 1) apply_vec(1, tag);
      if (c == 1000) begin
        for (int k = 0; k < N; k++) begin
          if (xs[k] >= 1024 || ys[k] >= 1024) range_bad++;
          snap_x[k] = xs[k]; snap_y[k] = ys[k];
        end
        check({tag, " coord_range"}, range_bad, 0);
      end
      if (c > 1000) begin
        for (int k = 0; k < N; k++)
          if (xs[k] !== snap_x[k] || ys[k] !== snap_y[k]) frozen_bad++;
      end
      if (c % 100 == 0) begin
        if (!is_perm()) perm_bad++;
        if (c > N + 1) begin
          len = dut_len();
          if (prev_len >= 0 && len > prev_len) incr_bad++;
          prev_len = len;
        end
      end
      if (c % 2000 == 0) begin
        check($sformatf("%s trace@%0d", tag, c), bad, 0);
        bad = 0;
      end
    end
    check({tag, " coords_frozen"}, frozen_bad, 0);
    check({tag, " permutation"}, perm_bad, 0);
    check({tag, " len_nonincreasing"}, incr_bad, 0);
    check({tag, " len_below_identity"}, longint'(dut_len() < ident_len()), 1);
  endtask

  initial begin
    // Reset-state vectors.
    vt.push_back('{"rst path[0]",  0, 0, 0,  0});
    vt.push_back('{"rst path[17]", 0, 0, 17, 17});
    vt.push_back('{"rst path[63]", 0, 0, 63, 63});
    vt.push_back('{"rst xs[0]",    0, 1, 0,  0});
    vt.push_back('{"rst xs[63]",   0, 1, 63, 0});
    vt.push_back('{"rst ys[5]",    0, 2, 5,  0});
    vt.push_back('{"rst ys[63]",   0, 2, 63, 0});
    // First xorshift32 step from 0x2463534A gives 0x8F4CBDAF:
    // x0 = bits[9:0] = 0x1AF = 431, y0 = bits[25:16] = 0x34C = 844.
    vt.push_back('{"init xs[0]",   1, 1, 0,  431});
    vt.push_back('{"init ys[0]",   1, 2, 0,  844});
    vt.push_back('{"init path[0]", 1, 0, 0,  0});
    vt.push_back('{"init path[40]",1, 0, 40, 40});
    vt.push_back('{"init path[63]",1, 0, 63, 63});

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    apply_vec(0, "por");
    rst = 1'b0;
    run(6000, "run1");

    // Mid-run reset raised between edges: outputs must clear before any clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 apply_vec(0, "async");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(40000, "run2");

    $display("coverage: a==b %0d, (0,%0d) %0d, a=0 %0d, b=%0d %0d, swaps %0d",
             cov_eq, N-1, cov_full, cov_a0, N-1, cov_b63, cov_swap);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
